// File: rtl/segway_cmd_pkg.sv
// rtl/segway_cmd_pkg.sv - shared command codes and state types for the Segway command front end
package segway_cmd_pkg;

    localparam logic [7:0] CMD_START = 8'h47;
    localparam logic [7:0] CMD_STOP  = 8'h53;

    typedef enum logic [1:0] {
        OFF,
        PWRD,
        STOPPING
    } auth_state_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic logic is_auth_cmd(input logic [7:0] b);
        return (b == CMD_START) || (b == CMD_STOP);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with input synchronizer and stop-bit check
module uart_rx_core
    import segway_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err
);

    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);

    logic            rx_m;
    logic            rx_s;
    rx_state_t       state;
    logic [CW-1:0]   baud_cnt;
    logic [3:0]      bit_cnt;
    logic [7:0]      shift;

    // Both stages reset high so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_rdy   <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            rx_rdy  <= 1'b0;
            frm_err <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    // Mid-bit recheck filters glitches shorter than half a bit.
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        shift    <= {rx_s, shift[7:1]};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= IDLE;
                        if (rx_s) begin
                            rx_data <= shift;
                            rx_rdy  <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/auth_cmd_rx.sv
// rtl/auth_cmd_rx.sv - UART command receiver and power-up authorization FSM driving pwr_up
module auth_cmd_rx
    import segway_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err
);

    auth_state_t state;
    auth_state_t nxt;
    logic        got_start;
    logic        got_stop;

    uart_rx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .frm_err (frm_err)
    );

    assign got_start = rx_rdy && is_auth_cmd(rx_data) && (rx_data == CMD_START);
    assign got_stop  = rx_rdy && is_auth_cmd(rx_data) && (rx_data == CMD_STOP);

    // A 'G' arriving with rider_off in STOPPING takes priority over shutdown.
    always_comb begin
        nxt = state;
        case (state)
            OFF: begin
                if (got_start) nxt = PWRD;
            end
            PWRD: begin
                if (got_stop) nxt = rider_off ? OFF : STOPPING;
            end
            STOPPING: begin
                if (got_start)      nxt = PWRD;
                else if (rider_off) nxt = OFF;
            end
            default: nxt = OFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= OFF;
            pwr_up <= 1'b0;
        end else begin
            state  <= nxt;
            pwr_up <= (nxt != OFF);
        end
    end

endmodule

// File: tb/tb_auth_cmd_rx.sv
// tb/tb_auth_cmd_rx.sv - self-checking bench for auth_cmd_rx with vector table and random model
module tb_auth_cmd_rx;

    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b1;
    logic       rider_off = 1'b0;
    logic       pwr_up;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frm_err;

    int checks = 0;
    int errors = 0;

    int         rdy_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] last_data = 8'h00;
    logic       pwr_at_rdy = 1'b0;
    logic       pwr_after = 1'b0;
    logic       pend = 1'b0;

    always #5 clk = ~clk;

    auth_cmd_rx #(.BAUD_DIV(BD)) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .rider_off (rider_off),
        .pwr_up    (pwr_up),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .frm_err   (frm_err)
    );

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pwr_after = pwr_up;
                pend = 1'b0;
            end
            if (rx_rdy) begin
                rdy_cnt++;
                last_data = rx_data;
                pwr_at_rdy = pwr_up;
                pend = 1'b1;
            end
            if (frm_err) ferr_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Reference: 'G' always authorizes, 'S' only acts while driving, rider_off finishes a pending stop.
    localparam int M_OFF = 0, M_PWRD = 1, M_STOPPING = 2;

    function automatic int model_byte(input int st, input logic [7:0] b, input logic ro);
        if (b == 8'h47) return M_PWRD;
        if (b == 8'h53 && st == M_PWRD) return ro ? M_OFF : M_STOPPING;
        return st;
    endfunction

    function automatic int model_settle(input int st, input logic ro);
        return (st == M_STOPPING && ro) ? M_OFF : st;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       ro;
        logic       exp_rdy;
        logic       exp_ferr;
        logic [7:0] exp_data;
        logic       exp_pwr;
    } vec_t;

    vec_t vecs[10];

    task automatic run_frame(input string tag, input logic [7:0] d, input logic stop,
                             input logic e_rdy, input logic e_ferr, input logic [7:0] e_data,
                             input logic e_pwr_before, input logic e_pwr);
        int r0, f0;
        r0 = rdy_cnt;
        f0 = ferr_cnt;
        send_frame(d, stop, 20);
        chk({tag, ".rdy_pulses"}, rdy_cnt - r0, {31'd0, e_rdy});
        chk({tag, ".ferr_pulses"}, ferr_cnt - f0, {31'd0, e_ferr});
        chk({tag, ".rx_data"}, rx_data, e_data);
        chk({tag, ".pwr_up"}, pwr_up, e_pwr);
        if (e_rdy) begin
            chk({tag, ".pwr_at_rdy"}, pwr_at_rdy, e_pwr_before);
            chk({tag, ".pwr_after_rdy"}, pwr_after, e_pwr);
            chk({tag, ".data_at_rdy"}, last_data, e_data);
        end
    endtask

    initial begin
        int st;
        int r0, f0, n;
        logic [7:0] cur_data;
        logic [7:0] b;
        logic sb, prev_pwr;

        vecs[0] = '{8'h47, 1'b1, 1'b0, 1'b1, 1'b0, 8'h47, 1'b1};
        vecs[1] = '{8'h53, 1'b1, 1'b0, 1'b1, 1'b0, 8'h53, 1'b1};
        vecs[2] = '{8'h47, 1'b1, 1'b0, 1'b1, 1'b0, 8'h47, 1'b1};
        vecs[3] = '{8'h53, 1'b1, 1'b1, 1'b1, 1'b0, 8'h53, 1'b0};
        vecs[4] = '{8'h41, 1'b1, 1'b1, 1'b1, 1'b0, 8'h41, 1'b0};
        vecs[5] = '{8'h47, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0};
        vecs[6] = '{8'h47, 1'b1, 1'b0, 1'b1, 1'b0, 8'h47, 1'b1};
        vecs[7] = '{8'h41, 1'b1, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1};
        vecs[8] = '{8'h53, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1};
        vecs[9] = '{8'h53, 1'b1, 1'b0, 1'b1, 1'b0, 8'h53, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset.pwr_up", pwr_up, 0);
        chk("reset.rx_rdy", rx_rdy, 0);
        chk("reset.frm_err", frm_err, 0);
        chk("reset.rx_data", rx_data, 8'h00);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("idle.pwr_up", pwr_up, 0);
        chk("idle.rdy_pulses", rdy_cnt, 0);
        chk("idle.ferr_pulses", ferr_cnt, 0);
        chk("idle.rx_data", rx_data, 8'h00);

        prev_pwr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rider_off = vecs[i].ro;
            @(negedge clk);
            run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].stop, vecs[i].exp_rdy,
                      vecs[i].exp_ferr, vecs[i].exp_data, prev_pwr, vecs[i].exp_pwr);
            prev_pwr = vecs[i].exp_pwr;
        end

        // Stopping completes exactly one clock after rider_off rises.
        rider_off = 1'b1;
        chk("stopping.pwr_same_cycle", pwr_up, 1);
        @(negedge clk);
        chk("stopping.pwr_next_cycle", pwr_up, 0);
        repeat (5) @(negedge clk);
        chk("stopping.pwr_stays_off", pwr_up, 0);

        // 'G' and rider_off together in STOPPING: 'G' wins.
        rider_off = 1'b0;
        @(negedge clk);
        run_frame("gwin.g1", 8'h47, 1'b1, 1'b1, 1'b0, 8'h47, 1'b0, 1'b1);
        run_frame("gwin.s", 8'h53, 1'b1, 1'b1, 1'b0, 8'h53, 1'b1, 1'b1);
        fork
            send_frame(8'h47, 1'b1, 20);
            begin
                n = 0;
                @(negedge clk);
                while (!rx_rdy && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                if (rx_rdy) rider_off = 1'b1;
                chk("gwin.rdy_seen", rx_rdy, 1);
            end
        join
        chk("gwin.pwr_up", pwr_up, 1);
        chk("gwin.rx_data", rx_data, 8'h47);
        rider_off = 1'b0;
        @(negedge clk);

        // Back-to-back frames with no idle gap.
        r0 = rdy_cnt;
        send_frame(8'h53, 1'b1, 0);
        send_frame(8'h41, 1'b1, 20);
        chk("b2b.rdy_pulses", rdy_cnt - r0, 2);
        chk("b2b.rx_data", rx_data, 8'h41);
        chk("b2b.pwr_up", pwr_up, 1);
        rider_off = 1'b1;
        repeat (2) @(negedge clk);
        chk("b2b.pwr_off", pwr_up, 0);
        rider_off = 1'b0;

        // Glitch shorter than half a bit is rejected.
        r0 = rdy_cnt;
        f0 = ferr_cnt;
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch.rdy_pulses", rdy_cnt - r0, 0);
        chk("glitch.ferr_pulses", ferr_cnt - f0, 0);
        run_frame("glitch.follow", 8'h41, 1'b1, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0);

        // Random frames against the reference model.
        st = M_OFF;
        cur_data = 8'h41;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(3) == 0) begin
                rider_off = ~rider_off;
                st = model_settle(st, rider_off);
                repeat (2) @(negedge clk);
                chk($sformatf("rnd%0d.ro_pwr", i), pwr_up, {31'd0, st != M_OFF});
            end
            case ($urandom_range(3))
                0: b = 8'h47;
                1: b = 8'h53;
                default: b = 8'($urandom_range(255));
            endcase
            sb = ($urandom_range(9) != 0);
            prev_pwr = (st != M_OFF);
            if (sb) begin
                st = model_settle(model_byte(st, b, rider_off), rider_off);
                cur_data = b;
            end
            run_frame($sformatf("rnd%0d", i), b, sb, sb, !sb, cur_data, prev_pwr, st != M_OFF);
        end

        // Reset during bit 4 of 0x47 aborts the byte.
        rider_off = 1'b0;
        r0 = rdy_cnt;
        f0 = ferr_cnt;
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            b = 8'h47;
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = 1'b0;
        repeat (BD / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        rst = 1'b0;
        repeat (BD * 6) @(negedge clk);
        chk("midrst.rdy_pulses", rdy_cnt - r0, 0);
        chk("midrst.ferr_pulses", ferr_cnt - f0, 0);
        chk("midrst.pwr_up", pwr_up, 0);
        chk("midrst.rx_data", rx_data, 8'h00);
        run_frame("midrst.resend", 8'h47, 1'b1, 1'b1, 1'b0, 8'h47, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
